router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-reception controller for the 1x3 router.
- Watches the input byte stream (pkt_valid, data_in) and sequences the register and synchronizer blocks through these phases: header decode, first-byte load, payload load, FIFO-full stall, parity load and parity check.
- Outputs are the state strobes consumed by the input register block and by the synchronizer's write-enable path (write_enb_reg, detect_add).
- One instance per router, located between the top-level input port and the synchronizer/register pair.

Parameters:
- None. Address width is fixed at 2 bits; there are three destination ports (addresses 0..2); address 3 is invalid.

Ports:
- clock  input  1  system clock, all state on rising edge
- resetn  input  1  synchronous, active-low reset
- pkt_valid  input  1  high while a packet byte (header/payload) is present; falls for the parity byte
- data_in  input  2  header address bits [1:0] of the input byte, sampled in DECODE_ADDRESS
- fifo_full  input  1  selected destination FIFO full (from synchronizer)
- fifo_empty_0/1/2  input  1 each  destination FIFO empty flags
- soft_reset_0/1/2  input  1 each  per-port timeout reset (from synchronizer)
- parity_done  input  1  register block has captured the parity byte
- low_pkt_valid  input  1  register block saw pkt_valid fall while stalled
- detect_add  output  1  header decode strobe (latches address in synchronizer)
- lfd_state  output  1  load-first-data (header) strobe
- ld_state  output  1  load-payload strobe
- laf_state  output  1  load-after-full strobe
- full_state  output  1  FIFO-full stall indicator
- write_enb_reg  output  1  FIFO write permit
- rst_int_reg  output  1  parity-check strobe, clears internal parity flags
- busy  output  1  input port must hold its current byte

Behaviour:
- State register: 3 bits.
  - States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
  - resetn low at a clock edge -> DECODE_ADDRESS and addr_reg=0, regardless of state.
- addr_reg (2 bits): loads data_in on every clock edge in DECODE_ADDRESS while pkt_valid=1; otherwise holds.
  - sel_empty = fifo_empty_[addr_reg] in all states except DECODE_ADDRESS, which uses fifo_empty_[data_in].
  - sel_soft = soft_reset_[addr_reg]. For addr_reg=3, sel_empty=0 and sel_soft=0.
- Transition priority per edge: resetn, then sel_soft, then the state rules below.
  - sel_soft=1 in any state other than DECODE_ADDRESS -> DECODE_ADDRESS.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in<3, sel_empty=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in<3, sel_empty=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay; invalid packets are ignored.
- WAIT_TILL_EMPTY: sel_empty=1 -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly 1 cycle).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay. fifo_full wins if both occur.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR (1 cycle).
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- Outputs are Moore (decoded from state only, no added latency):
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS and LOAD_DATA
- Reset values of outputs: detect_add=1; all other outputs 0.
- Unused state encodings -> DECODE_ADDRESS on next edge; outputs all 0 meanwhile.
- Reset or soft reset mid-packet: packet abandoned; remaining bytes are treated as a new header attempt only once pkt_valid is seen in DECODE_ADDRESS.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> state DECODE_ADDRESS, detect_add=1, busy=0, write_enb_reg=0.
- Normal packet to port 1 (fifo_empty_1=1):
  - Stimulus: header data_in=01 with pkt_valid=1, then 4 payload cycles, then pkt_valid=0.
  - Response: lfd_state high 1 cycle; ld_state high 4 cycles; LOAD_PARITY 1 cycle (write_enb_reg=1, busy=1); rst_int_reg 1 cycle; back to detect_add=1.
- Busy destination, address 2 with fifo_empty_2=0:
  - Stays in WAIT_TILL_EMPTY with busy=1, write_enb_reg=0.
  - Raise fifo_empty_2 -> LOAD_FIRST_DATA next edge.
- Full stall: in LOAD_DATA raise fifo_full for 3 cycles.
  - full_state=1 and busy=1 for those cycles, then laf_state=1 for 1 cycle.
  - With low_pkt_valid=1, parity_done=0 -> LOAD_PARITY. Repeat with parity_done=1 -> DECODE_ADDRESS.
- Invalid address: header data_in=11, pkt_valid=1 for 5 cycles -> remains DECODE_ADDRESS; lfd_state and write_enb_reg never assert.
- Soft reset: during LOAD_DATA to port 0, pulse soft_reset_0 -> DECODE_ADDRESS on next edge. The same pulse on soft_reset_1 has no effect.

Source files
------------

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: decodes the header address,
// then sequences the register/synchronizer strobes through load, stall and parity phases.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    // state              | meaning
    // DECODE_ADDRESS     | idle, waiting for a header byte with a valid address
    // LOAD_FIRST_DATA    | header byte written to the destination FIFO
    // LOAD_DATA          | payload bytes streaming into the FIFO
    // LOAD_PARITY        | parity byte written
    // FIFO_FULL_STATE    | destination full, input held
    // LOAD_AFTER_FULL    | byte held during the stall is written
    // WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
    // CHECK_PARITY_ERROR | parity comparison, internal flags cleared
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state, state_next;
    logic [1:0] addr_reg;
    logic [1:0] empty_idx;
    logic       sel_empty;
    logic       sel_soft;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'd0;
        end else begin
            state <= state_next;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_reg <= data_in;
        end
    end

    // The header byte is still on data_in while decoding, so look ahead at its FIFO.
    assign empty_idx = (state == DECODE_ADDRESS) ? data_in : addr_reg;

    always_comb begin
        sel_empty = 1'b0;
        case (empty_idx)
            2'd0:    sel_empty = fifo_empty_0;
            2'd1:    sel_empty = fifo_empty_1;
            2'd2:    sel_empty = fifo_empty_2;
            default: sel_empty = 1'b0;
        endcase
    end

    always_comb begin
        sel_soft = 1'b0;
        case (addr_reg)
            2'd0:    sel_soft = soft_reset_0;
            2'd1:    sel_soft = soft_reset_1;
            2'd2:    sel_soft = soft_reset_2;
            default: sel_soft = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (sel_soft && state != DECODE_ADDRESS) begin
            state_next = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3)
                        state_next = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)
                        state_next = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_next = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        state_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_next = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_next = LOAD_PARITY;
                    else
                        state_next = LOAD_DATA;
                end
                LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_next = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; end
            LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin write_enb_reg = 1'b1; busy = 1'b1; end
            FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
            LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a phase-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    router_fsm dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference model: packet phase tracked as a small integer, outputs from a table.
    localparam int PH_IDLE = 0, PH_HDR = 1, PH_PAY = 2, PH_PAR = 3;
    localparam int PH_STALL = 4, PH_RESUME = 5, PH_WAITQ = 6, PH_CHK = 7;
    int  m_phase = PH_IDLE;
    int  m_port  = 0;
    bit  m_live  = 0;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    function automatic logic [7:0] expected_outs(int ph);
        case (ph)
            PH_IDLE:   return 8'b1000_0000;
            PH_HDR:    return 8'b0100_0001;
            PH_PAY:    return 8'b0010_0100;
            PH_PAR:    return 8'b0000_0101;
            PH_STALL:  return 8'b0000_1001;
            PH_RESUME: return 8'b0001_0101;
            PH_WAITQ:  return 8'b0000_0001;
            default:   return 8'b0000_0011;
        endcase
    endfunction

    function automatic bit port_empty(int p);
        bit e[3];
        e[0] = fifo_empty_0; e[1] = fifo_empty_1; e[2] = fifo_empty_2;
        return (p < 3) ? e[p] : 1'b0;
    endfunction

    function automatic bit port_soft(int p);
        bit s[3];
        s[0] = soft_reset_0; s[1] = soft_reset_1; s[2] = soft_reset_2;
        return (p < 3) ? s[p] : 1'b0;
    endfunction

    always @(posedge clock) begin
        int nxt;
        m_live = 1;
        if (!resetn) begin
            m_phase = PH_IDLE;
            m_port  = 0;
        end else begin
            nxt = m_phase;
            if (m_phase != PH_IDLE && port_soft(m_port))
                nxt = PH_IDLE;
            else if (m_phase == PH_IDLE) begin
                if (pkt_valid && int'(data_in) < 3)
                    nxt = port_empty(int'(data_in)) ? PH_HDR : PH_WAITQ;
            end else if (m_phase == PH_WAITQ)
                nxt = port_empty(m_port) ? PH_HDR : PH_WAITQ;
            else if (m_phase == PH_HDR)
                nxt = PH_PAY;
            else if (m_phase == PH_PAY)
                nxt = fifo_full ? PH_STALL : (!pkt_valid ? PH_PAR : PH_PAY);
            else if (m_phase == PH_STALL)
                nxt = fifo_full ? PH_STALL : PH_RESUME;
            else if (m_phase == PH_RESUME)
                nxt = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PAR : PH_PAY);
            else if (m_phase == PH_PAR)
                nxt = PH_CHK;
            else
                nxt = fifo_full ? PH_STALL : PH_IDLE;
            if (m_phase == PH_IDLE && pkt_valid)
                m_port = int'(data_in);
            m_phase = nxt;
        end
    end

    always @(negedge clock) begin
        logic [7:0] act, exp_o;
        if (m_live) begin
            act   = {detect_add, lfd_state, ld_state, laf_state, full_state,
                     write_enb_reg, rst_int_reg, busy};
            exp_o = expected_outs(m_phase);
            n_cmp++;
            if (act !== exp_o) begin
                n_fail++;
                $display("FAIL model_outs t=%0t got=%b expected=%b", $time, act, exp_o);
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ld_count;
        resetn = 0; pkt_valid = 0; data_in = 0; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_pkt_valid = 0;

        tick(); tick();
        check("reset_detect", detect_add, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_wenb", write_enb_reg, 1'b0);
        resetn = 1;

        // normal packet to port 1
        pkt_valid = 1; data_in = 2'd1;
        tick();
        check("p1_lfd", lfd_state, 1'b1);
        check("p1_lfd_busy", busy, 1'b1);
        ld_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ld_state === 1'b1) ld_count++;
        end
        n_cmp++;
        if (ld_count != 4) begin
            n_fail++;
            $display("FAIL p1_ld_cycles got=%0d expected=4", ld_count);
        end
        pkt_valid = 0;
        tick();
        check("p1_par_wenb", write_enb_reg, 1'b1);
        check("p1_par_busy", busy, 1'b1);
        check("p1_par_ld", ld_state, 1'b0);
        tick();
        check("p1_rst_int", rst_int_reg, 1'b1);
        tick();
        check("p1_back_idle", detect_add, 1'b1);

        // busy destination port 2
        fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'd2;
        tick();
        check("wait_busy", busy, 1'b1);
        check("wait_wenb", write_enb_reg, 1'b0);
        tick(); tick();
        check("wait_hold_lfd", lfd_state, 1'b0);
        check("wait_hold_detect", detect_add, 1'b0);
        fifo_empty_2 = 1;
        tick();
        check("wait_to_lfd", lfd_state, 1'b1);
        tick();
        check("p2_ld", ld_state, 1'b1);

        // full stall for three cycles, then resume into parity
        fifo_full = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_full", full_state, 1'b1);
            check("stall_busy", busy, 1'b1);
        end
        fifo_full = 0;
        tick();
        check("laf", laf_state, 1'b1);
        low_pkt_valid = 1;
        tick();
        check("laf_to_par", write_enb_reg & busy & ~laf_state, 1'b1);
        low_pkt_valid = 0; pkt_valid = 0;
        tick();
        check("par_chk", rst_int_reg, 1'b1);
        tick();
        check("chk_idle", detect_add, 1'b1);

        // stall resumed with parity already captured
        pkt_valid = 1; data_in = 2'd0;
        tick(); tick();
        fifo_full = 1;
        tick();
        fifo_full = 0;
        tick();
        check("laf2", laf_state, 1'b1);
        parity_done = 1; pkt_valid = 0;
        tick();
        check("laf_done_idle", detect_add, 1'b1);
        parity_done = 0;

        // invalid address 3
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("inv_detect", detect_add, 1'b1);
            check("inv_lfd", lfd_state, 1'b0);
            check("inv_wenb", write_enb_reg, 1'b0);
        end

        // soft reset on the wrong then the right port
        data_in = 2'd0;
        tick(); tick();
        check("sr_ld", ld_state, 1'b1);
        soft_reset_1 = 1;
        tick();
        check("sr_other_port", ld_state, 1'b1);
        soft_reset_1 = 0; soft_reset_0 = 1;
        tick();
        check("sr_own_port", detect_add, 1'b1);
        soft_reset_0 = 0; pkt_valid = 0;
        tick();

        // parity check straight into full stall
        pkt_valid = 1; data_in = 2'd1;
        tick(); tick();
        pkt_valid = 0;
        tick(); tick();
        check("chk_rst", rst_int_reg, 1'b1);
        fifo_full = 1;
        tick();
        check("chk_to_full", full_state, 1'b1);
        fifo_full = 0;
        tick();
        parity_done = 1;
        tick();
        parity_done = 0;

        // hard reset mid-packet
        pkt_valid = 1; data_in = 2'd2;
        tick(); tick();
        check("hr_ld", ld_state, 1'b1);
        resetn = 0; pkt_valid = 0;
        tick();
        check("hr_idle", detect_add, 1'b1);
        resetn = 1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
